pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, flush, and a global start gate. It replaces the fixed-field, enable-only stage registers between core stages. It can apply back-pressure without losing an instruction, and it forces control bits to zero on bubbles so that write enables never fire spuriously. It sits between any two pipeline stages of the RV32 + SHA core. It also carries a saturating stall counter for performance debug.

## Interface
Parameters:
- DATA_W, default 32: payload width (inst, pc, result, …, concatenated by the instantiating stage)
- CTRL_W, default 16: control-bit width (reg_write, mem_write, branch, start_sha, …)
- CLEAR_ON_IDLE, default 1: 1 = payload registers zeroed on flush/drain; 0 = payload held, only valid cleared
- CNT_W, default 16: stall counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  global run enable; low = stage flushed every cycle
- flush  in  1  synchronous kill of all held entries (branch/jump redirect)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; in_ready = start & ~skid_valid
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  main payload
- out_ctrl  out  CTRL_W  main control bits, forced 0 when out_valid=0
- occupancy  out  2  entries held: 0, 1 or 2
- clr_stats  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready, saturating

## Operation
- Handshake events:
  - acc = in_valid & in_ready
  - fire = out_valid & out_ready
- Storage: main register (main_valid, data, ctrl) and skid register (skid_valid, data, ctrl).
- State follows {main_valid, skid_valid}:
  - EMPTY (0,0):
    - acc → FULL, main ← in
  - FULL (1,0):
    - fire & acc → FULL, main ← in
    - fire & ~acc → EMPTY
    - ~fire & acc → SKID, skid ← in, main held
    - ~fire & ~acc → hold
  - SKID (1,1): in_ready = 0.
    - fire → FULL, main ← skid, skid cleared
    - otherwise hold
- Flush: flush=1 or start=0 → next state EMPTY.
  - Flush has priority over acc and all transitions.
  - With CLEAR_ON_IDLE=1, all data/ctrl registers ← 0.
  - A fire in the flush cycle still completes downstream, because outputs are valid that cycle.
- Drain (FULL→EMPTY on fire) with CLEAR_ON_IDLE=1: main data/ctrl ← 0.
- out_ctrl gating is combinational on main_valid, independent of CLEAR_ON_IDLE.
- Order is strict FIFO; no entry is dropped or duplicated except by flush.
- occupancy = main_valid + skid_valid.
- Stall counter:
  - increments when out_valid & ~out_ready; saturates at all ones.
  - clr_stats → 0, with priority over increment.
  - Unaffected by flush and start.

## Timing
- Reset (reset=0, asynchronous): out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, skid empty; in_ready=start.
- Latency: acc at edge N → out_valid=1 with that data after edge N, i.e. 1 cycle.
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready depends only on registered state and start; there is no combinational path from out_ready to in_ready.
- After out_ready drops, the stage absorbs exactly one more entry (skid); in_ready falls the cycle after the skid fills.
- Reset asserted mid-operation: both entries are lost immediately; outputs go to reset values without waiting for clk.
- start low for one cycle with data held: the next cycle is EMPTY with outputs zero, matching the legacy stage-register bubble behaviour.

## Test plan
- Reset then streaming: start=1, out_ready=1, in_valid=1 with in_data=0x00000013,0x00100093,0x00200113 on consecutive cycles → the same values appear on out_data one cycle later each; occupancy stays 1; stall_cnt=0.
- Back-pressure and skid:
  - out_ready=0 while sending 0xA,0xB,0xC → stage holds 0xA main and 0xB skid; occupancy=2; in_ready=0; 0xC is not accepted.
  - out_ready=1 → outputs 0xA, 0xB, then 0xC in order.
- Flush priority: state SKID, flush=1 with in_valid=1 → next cycle occupancy=0, out_valid=0, out_ctrl=0, out_data=0 (CLEAR_ON_IDLE=1); the in_data of the flush cycle is not stored.
- Bubble ctrl gating: CLEAR_ON_IDLE=0, drain entry with ctrl=0xFFFF → out_ctrl=0 while out_valid=0, out_data retains the last payload.
- Stall counter: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt saturates at 15; clr_stats pulse in a stall cycle → stall_cnt=0 the next cycle.
- Async reset mid-stream: reset low between clock edges while occupancy=2 → out_valid=0 and occupancy=0 immediately; after release, the first acc produces out_valid one cycle later.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, a one-entry skid buffer,
// flush/start gating and a saturating stall counter for performance debug.
module pipe_stage_skid #(
  parameter int DATA_W        = 32,
  parameter int CTRL_W        = 16,
  parameter bit CLEAR_ON_IDLE = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding is {main_valid, skid_valid}, so the valid bits fall out of the state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, main_data_nxt, skid_data, skid_data_nxt;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
  logic              main_valid, skid_valid;
  logic              acc, fire, stall;

  assign main_valid = state[1];
  assign skid_valid = state[0];

  // in_ready comes only from registered state and start, never from out_ready.
  assign in_ready  = start & ~skid_valid;
  assign acc       = in_valid & in_ready;
  assign fire      = main_valid & out_ready;
  assign stall     = main_valid & ~out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt     = state;
    main_data_nxt = main_data;
    main_ctrl_nxt = main_ctrl;
    skid_data_nxt = skid_data;
    skid_ctrl_nxt = skid_ctrl;

    unique case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt     = FULL;
          main_data_nxt = in_data;
          main_ctrl_nxt = in_ctrl;
        end
      end
      FULL: begin
        if (fire && acc) begin
          main_data_nxt = in_data;
          main_ctrl_nxt = in_ctrl;
        end else if (fire) begin
          state_nxt = EMPTY;
          if (CLEAR_ON_IDLE) begin
            main_data_nxt = '0;
            main_ctrl_nxt = '0;
          end
        end else if (acc) begin
          state_nxt     = SKID;
          skid_data_nxt = in_data;
          skid_ctrl_nxt = in_ctrl;
        end
      end
      SKID: begin
        if (fire) begin
          state_nxt     = FULL;
          main_data_nxt = skid_data;
          main_ctrl_nxt = skid_ctrl;
          if (CLEAR_ON_IDLE) begin
            skid_data_nxt = '0;
            skid_ctrl_nxt = '0;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase

    // Redirects and a stopped core override any transition, including an acc.
    if (flush || !start) begin
      state_nxt = EMPTY;
      if (CLEAR_ON_IDLE) begin
        main_data_nxt = '0;
        main_ctrl_nxt = '0;
        skid_data_nxt = '0;
        skid_ctrl_nxt = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the payload registers are reset too, because out_data must read
  // zero straight out of reset rather than whatever powered up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      main_data <= main_data_nxt;
      main_ctrl <= main_ctrl_nxt;
      skid_data <= skid_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
    end
  end

  // Stall counter ignores flush and start so redirects do not hide back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, skid back-pressure, flush,
// start bubbles, bubble ctrl gating, stall saturation and async reset.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset, start, flush, in_valid, out_ready, clr_stats;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] out_data0, out_data1;
  logic [15:0] out_ctrl0, out_ctrl1;
  logic [1:0]  occ0, occ1;
  logic [3:0]  stall0;
  logic [15:0] stall1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Clearing variant with a narrow counter to exercise saturation.
  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .CLEAR_ON_IDLE(1'b1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .occupancy(occ0), .clr_stats(clr_stats), .stall_cnt(stall0)
  );

  // Holding variant driven by the same stimulus.
  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .CLEAR_ON_IDLE(1'b0), .CNT_W(16)) dut_hold (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_ctrl(out_ctrl1), .occupancy(occ1), .clr_stats(clr_stats), .stall_cnt(stall1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [15:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; clr_stats = 1'b0; in_data = '0; in_ctrl = '0;

    // Reset state
    #1;
    check("rst_out_valid", {31'b0, out_valid0}, 32'h0);
    check("rst_out_data",  out_data0, 32'h0);
    check("rst_out_ctrl",  {16'b0, out_ctrl0}, 32'h0);
    check("rst_occ",       {30'b0, occ0}, 32'h0);
    check("rst_stall",     {28'b0, stall0}, 32'h0);
    check("rst_in_ready_start0", {31'b0, in_ready0}, 32'h0);
    start = 1'b1;
    #1;
    check("rst_in_ready_start1", {31'b0, in_ready0}, 32'h1);
    #10 reset = 1'b1;

    // Streaming at full throughput
    out_ready = 1'b1;
    send(32'h0000_0013, 16'h0001);
    step();
    check("stream0_data", out_data0, 32'h0000_0013);
    check("stream0_ctrl", {16'b0, out_ctrl0}, 32'h1);
    check("stream0_occ",  {30'b0, occ0}, 32'h1);
    send(32'h0010_0093, 16'h0002);
    step();
    check("stream1_data", out_data0, 32'h0010_0093);
    check("stream1_occ",  {30'b0, occ0}, 32'h1);
    send(32'h0020_0113, 16'h0003);
    step();
    check("stream2_data", out_data0, 32'h0020_0113);
    check("stream2_occ",  {30'b0, occ0}, 32'h1);
    in_valid = 1'b0;
    step();
    check("drain_valid", {31'b0, out_valid0}, 32'h0);
    check("drain_data_cleared", out_data0, 32'h0);
    check("stream_stall", {28'b0, stall0}, 32'h0);

    // Back-pressure into the skid buffer
    out_ready = 1'b0;
    send(32'hA, 16'h00AA);
    step();
    check("bp_a_main", out_data0, 32'hA);
    check("bp_a_ready", {31'b0, in_ready0}, 32'h1);
    send(32'hB, 16'h00BB);
    step();
    check("bp_skid_occ",   {30'b0, occ0}, 32'h2);
    check("bp_skid_ready", {31'b0, in_ready0}, 32'h0);
    check("bp_skid_main",  out_data0, 32'hA);
    send(32'hC, 16'h00CC);
    step();
    check("bp_c_rejected_occ",  {30'b0, occ0}, 32'h2);
    check("bp_c_rejected_main", out_data0, 32'hA);
    check("bp_stall2", {28'b0, stall0}, 32'h2);
    out_ready = 1'b1;
    step();
    check("bp_out_b", out_data0, 32'hB);
    check("bp_out_b_ctrl", {16'b0, out_ctrl0}, 32'h00BB);
    check("bp_out_b_occ", {30'b0, occ0}, 32'h1);
    step();
    check("bp_out_c", out_data0, 32'hC);
    in_valid = 1'b0;
    step();
    check("bp_empty_occ", {30'b0, occ0}, 32'h0);

    // Stall counter saturation and clear
    out_ready = 1'b0;
    send(32'h55, 16'hFFFF);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("stall_saturate", {28'b0, stall0}, 32'hF);
    clr_stats = 1'b1;
    step();
    check("stall_cleared", {28'b0, stall0}, 32'h0);
    clr_stats = 1'b0;
    step();
    check("stall_after_clear", {28'b0, stall0}, 32'h1);

    // Bubble ctrl gating on the holding variant
    check("gate_ctrl_valid", {16'b0, out_ctrl1}, 32'hFFFF);
    out_ready = 1'b1;
    step();
    check("gate_valid",      {31'b0, out_valid1}, 32'h0);
    check("gate_ctrl_zero",  {16'b0, out_ctrl1}, 32'h0);
    check("gate_data_held",  out_data1, 32'h55);
    check("gate_data_clear", out_data0, 32'h0);

    // Flush beats a simultaneous acc while in SKID
    out_ready = 1'b0;
    send(32'h111, 16'h0011);
    step();
    send(32'h222, 16'h0022);
    step();
    check("flush_pre_occ", {30'b0, occ0}, 32'h2);
    flush = 1'b1;
    send(32'h333, 16'h0033);
    step();
    check("flush_occ",   {30'b0, occ0}, 32'h0);
    check("flush_valid", {31'b0, out_valid0}, 32'h0);
    check("flush_ctrl",  {16'b0, out_ctrl0}, 32'h0);
    check("flush_data",  out_data0, 32'h0);
    check("flush_stall_counts", {28'b0, stall0}, 32'h3);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    check("flush_not_stored", {30'b0, occ0}, 32'h0);

    // One cycle of start low empties a held stage
    send(32'h444, 16'h0044);
    step();
    check("start_pre_occ", {30'b0, occ0}, 32'h1);
    in_valid = 1'b0;
    start = 1'b0;
    #1;
    check("start_low_in_ready", {31'b0, in_ready0}, 32'h0);
    step();
    check("start_bubble_occ",  {30'b0, occ0}, 32'h0);
    check("start_bubble_data", out_data0, 32'h0);
    start = 1'b1;

    // Async reset between edges while two entries are held
    send(32'h5, 16'h0005);
    step();
    send(32'h6, 16'h0006);
    step();
    check("arst_pre_occ", {30'b0, occ0}, 32'h2);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_valid", {31'b0, out_valid0}, 32'h0);
    check("arst_occ",   {30'b0, occ0}, 32'h0);
    check("arst_data",  out_data0, 32'h0);
    check("arst_in_ready", {31'b0, in_ready0}, 32'h1);
    #2 reset = 1'b1;
    out_ready = 1'b1;
    send(32'h7, 16'h0007);
    step();
    check("arst_first_valid", {31'b0, out_valid0}, 32'h1);
    check("arst_first_data",  out_data0, 32'h7);
    in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
